serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial front end for the sequence-detector stage: accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the single-bit `x` stream that the detector samples on each rising edge of `clk`. Back-to-back words stream with no idle gap, so the detector sees a continuous bit train. Sits directly upstream of the detector.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `CNT_W`, default 8: width of the word counter.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word; bit WIDTH-1 is sent first.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  block accepts `din` on this edge when `din_valid` is high.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a real bit this cycle.
- `x_last`  out  1  current `x` is the final bit of its frame.
- `busy`  out  1  a frame is in flight.
- `word_cnt`  out  CNT_W  number of frames fully sent, modulo 2^CNT_W.

## Operation
- One clock (`clk`). Reset is asynchronous and active-low (`rst_n`).
- Reset values: `x`=0, `x_valid`=0, `x_last`=0, `busy`=0, `word_cnt`=0, `din_ready`=1, state IDLE. Asserting `rst_n` mid-frame aborts the frame at once. The partial frame is not counted. `x` returns to 0 in the same instant, without waiting for a clock edge.
- FSM states: IDLE and SHIFT. PARITY is added when `SER_PARITY_EN` is defined.
- Frame length FL = WIDTH, or WIDTH+1 when `SER_PARITY_EN` is defined.
- IDLE:
  - `din_ready`=1.
  - On `din_valid`: load `din` into the shift register, clear the bit counter and go to SHIFT.
- SHIFT:
  - `x` = shift register MSB and `x_valid`=1.
  - Each edge shifts left and increments the bit counter, which counts 0..WIDTH-1.
- Last data bit (counter = WIDTH-1), parity disabled:
  - `x_last`=1 and `din_ready`=1.
  - If `din_valid`, load the next word and stay in SHIFT, so there is no gap. Otherwise go to IDLE.
  - `word_cnt` increments on this edge.
- Last data bit, parity enabled: go to PARITY; `din_ready` stays 0.
- In every other SHIFT cycle `din_ready`=0. A `din` change while not ready is ignored.
- `busy`=1 in SHIFT and PARITY.
- When `x_valid`=0, `x` is driven 0.
- `word_cnt` wraps from 2^CNT_W−1 to 0 silently.

## Timing
- `din_ready` is combinational from state and counter only. It never depends on `din_valid`.
- `x`, `x_valid`, `x_last` and `busy` are registered.
- Latency: word accepted on edge N; its MSB is on `x` in the cycle after edge N; bit k is on `x` in the cycle after edge N+k.
- Streaming throughput: one bit per clock. A word accepted during a last-bit cycle puts its MSB on `x` in the immediately following cycle.
- `x` is stable for the whole clock period, so the detector samples it on the next rising edge with full setup margin.
- No backpressure from downstream: once a frame is accepted it always completes unless `rst_n` is asserted.

## Configuration
- `SER_PARITY_EN` defined:
  - After the WIDTH data bits, one PARITY cycle drives `x` = even parity (XOR) of the loaded word.
  - In the PARITY cycle `x_valid`=1, `x_last`=1 and `din_ready`=1.
  - Back-to-back loading and the `word_cnt` increment move to the PARITY cycle.
- `SER_PARITY_EN` undefined:
  - The PARITY state and parity logic are absent.
  - FL = WIDTH, and `x_last` is asserted on data bit WIDTH-1.

## Test plan
- Reset: hold `rst_n`=0 with `din_valid`=1 → `x`=0, `x_valid`=0, `busy`=0, `word_cnt`=0, `din_ready`=1. Release `rst_n` → the word is accepted on the first edge.
- Single word: WIDTH=3, `din`=3'b010, one-cycle `din_valid` → `x` = 0,1,0 in the 3 cycles after acceptance, `x_last` on the third, then `x_valid`=0 and `word_cnt`=1.
- Back-to-back: WIDTH=3, words 3'b111 then 3'b010 with `din_valid` held high → continuous `x` = 1,1,1,0,1,0, `din_ready` high only in IDLE and the last-bit cycles, `word_cnt`=2.
- Ignored input: change `din` mid-frame while `din_ready`=0 → the serial output is unaffected.
- Reset mid-frame: WIDTH=8, `din`=8'hA5, assert `rst_n` after 4 bits → outputs return to reset values immediately and `word_cnt` is unchanged.
- Parity build (`SER_PARITY_EN`): WIDTH=3, `din`=3'b011 → `x` = 0,1,1 then 0 with `x_last` on the 4th cycle. `din`=3'b111 → 4th bit = 1.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// Define SER_PARITY_EN to append an even-parity bit after each word's data bits.
module serial_bit_feeder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             x_last,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int BCW = $clog2(WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
`ifdef SER_PARITY_EN
      S_PARITY = 2'd2,
`endif
      S_SHIFT  = 2'd1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [CNT_W-1:0] r_word_cnt;
   logic             r_x, r_x_valid, r_x_last, r_busy;
   logic             w_x_nxt, w_x_last_nxt;
   logic             w_load, w_word_done, w_last_bit;
`ifdef SER_PARITY_EN
   logic             r_parity, w_parity_nxt;
`endif

   assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);

   // Ready is a function of state and bit counter only, never of din_valid.
`ifdef SER_PARITY_EN
   assign din_ready = (r_state == S_IDLE) || (r_state == S_PARITY);
   assign w_parity_nxt = w_load ? ^din : r_parity;
`else
   assign din_ready = (r_state == S_IDLE) || w_last_bit;
`endif

   assign w_load = din_valid && din_ready;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_word_done   = 1'b0;
      case (r_state)
         S_IDLE: ;
         S_SHIFT: begin
            if (w_last_bit) begin
`ifdef SER_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_word_done = 1'b1;
               w_state_nxt = S_IDLE;
`endif
            end else begin
               w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
               w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            end
         end
`ifdef SER_PARITY_EN
         S_PARITY: begin
            w_word_done = 1'b1;
            w_state_nxt = S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_load) begin
         w_shift_nxt   = din;
         w_bit_cnt_nxt = '0;
         w_state_nxt   = S_SHIFT;
      end
   end

   // Serial outputs are computed from next state so they can be registered.
   always_comb begin
      w_x_nxt      = 1'b0;
      w_x_last_nxt = 1'b0;
      case (w_state_nxt)
         S_SHIFT: begin
            w_x_nxt = w_shift_nxt[WIDTH-1];
`ifndef SER_PARITY_EN
            w_x_last_nxt = (w_bit_cnt_nxt == LAST_BIT);
`endif
         end
`ifdef SER_PARITY_EN
         S_PARITY: begin
            w_x_nxt      = w_parity_nxt;
            w_x_last_nxt = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_x        <= 1'b0;
         r_x_valid  <= 1'b0;
         r_x_last   <= 1'b0;
         r_busy     <= 1'b0;
`ifdef SER_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_x       <= w_x_nxt;
         r_x_valid <= (w_state_nxt != S_IDLE);
         r_x_last  <= w_x_last_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
`ifdef SER_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
         if (w_word_done) r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
   end

   assign x        = r_x;
   assign x_valid  = r_x_valid;
   assign x_last   = r_x_last;
   assign busy     = r_busy;
   assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: queue-based bit-stream model on a WIDTH=3 instance,
// directed checks on a WIDTH=8 instance. Honours SER_PARITY_EN when defined.
module tb_serial_bit_feeder;

   localparam int W3 = 3;
   localparam int C3 = 3;
   localparam int W8 = 8;
   localparam int C8 = 8;
`ifdef SER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FL3 = W3 + P;
   localparam int FL8 = W8 + P;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, din_valid, din_ready, x, x_valid, x_last, busy;
   logic [W3-1:0] din;
   logic [C3-1:0] word_cnt;

   logic          rst8_n, dv8, rdy8, x8, xv8, xl8, busy8;
   logic [W8-1:0] din8;
   logic [C8-1:0] wc8;

   serial_bit_feeder #(.WIDTH(W3), .CNT_W(C3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .x(x), .x_valid(x_valid), .x_last(x_last), .busy(busy), .word_cnt(word_cnt));

   serial_bit_feeder #(.WIDTH(W8), .CNT_W(C8)) u_dut8 (
      .clk(clk), .rst_n(rst8_n), .din(din8), .din_valid(dv8), .din_ready(rdy8),
      .x(x8), .x_valid(xv8), .x_last(xl8), .busy(busy8), .word_cnt(wc8));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the queue holds the bits still to appear on x; its head is the current bit.
   bit            m_q[$];
   logic [C3-1:0] m_cnt = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            m_cnt = '0;
         end else begin
            bit acc;
            acc = din_valid && (m_q.size() <= 1);
            if (m_q.size() > 0) begin
               if (m_q.size() == 1) m_cnt++;
               void'(m_q.pop_front());
            end
            if (acc) begin
               for (int k = W3 - 1; k >= 0; k--) m_q.push_back(din[k]);
               if (P == 1) m_q.push_back(^din);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("m_x_valid", x_valid, m_q.size() > 0);
         check("m_x", x, (m_q.size() > 0) ? m_q[0] : 1'b0);
         check("m_x_last", x_last, m_q.size() == 1);
         check("m_busy", busy, m_q.size() > 0);
         check("m_din_ready", din_ready, m_q.size() <= 1);
         check("m_word_cnt", word_cnt, m_cnt);
      end
   end

   logic [3:0]    single_x;
   logic [7:0]    b2b_x, b2b_last;
   logic [W3-1:0] b2b_first;
   logic [W3-1:0] b2b_din [8];
   int            b2b_n;
   logic [W8-1:0] w8;
   logic          exp_bit;

   initial begin
`ifdef SER_PARITY_EN
      single_x  = 4'b1010;
      b2b_first = 3'b011;
      b2b_n     = 8;
      b2b_x     = 8'b11110110;
      b2b_last  = 8'b10001000;
      b2b_din   = '{3'b000, 3'b101, 3'b110, 3'b111, 3'b000, 3'b010, 3'b100, 3'b000};
`else
      single_x  = 4'b0010;
      b2b_first = 3'b111;
      b2b_n     = 6;
      b2b_x     = 8'b00010111;
      b2b_last  = 8'b00100100;
      b2b_din   = '{3'b000, 3'b101, 3'b010, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000};
`endif
      rst_n = 1'b0; din = 3'b010; din_valid = 1'b1;
      rst8_n = 1'b0; din8 = '0; dv8 = 1'b0;

      // Reset with din_valid held high.
      repeat (2) @(negedge clk);
      check("rst_x", x, 0);
      check("rst_x_valid", x_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_din_ready", din_ready, 1);
      @(posedge clk); #2 rst_n = 1'b1;

      // Single word accepted on the first edge after release.
      @(posedge clk);
      for (int i = 0; i < FL3; i++) begin
         @(negedge clk);
         if (i == 0) din_valid = 1'b0;
         check("single_x", x, single_x[i]);
         check("single_last", x_last, i == FL3 - 1);
         check("single_x_valid", x_valid, 1);
      end
      @(negedge clk);
      check("single_idle_x_valid", x_valid, 0);
      check("single_word_cnt", word_cnt, 1);

      // Back-to-back words with din wiggling while not ready.
      din = b2b_first; din_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < b2b_n; i++) begin
         @(negedge clk);
         check("b2b_x", x, b2b_x[i]);
         check("b2b_last", x_last, b2b_last[i]);
         check("b2b_ready", din_ready, b2b_last[i]);
         din = b2b_din[i];
         if (i == b2b_n - 1) din_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_idle_x_valid", x_valid, 0);
      check("b2b_word_cnt", word_cnt, 3);

      // Wide instance: abort A5 after four bits, then two streamed random words.
      rst8_n = 1'b1; w8 = 8'hA5; din8 = w8; dv8 = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) dv8 = 1'b0;
         check("w8_abort_x", x8, w8[7-k]);
         check("w8_abort_x_valid", xv8, 1);
      end
      #2 rst8_n = 1'b0;
      #1;
      check("w8_rst_x", x8, 0);
      check("w8_rst_x_valid", xv8, 0);
      check("w8_rst_x_last", xl8, 0);
      check("w8_rst_busy", busy8, 0);
      check("w8_rst_ready", rdy8, 1);
      check("w8_rst_word_cnt", wc8, 0);
      @(negedge clk);
      rst8_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         w8 = W8'($urandom);
         din8 = w8; dv8 = 1'b1;
         @(posedge clk);
         for (int k = 0; k < FL8; k++) begin
            @(negedge clk);
            if (k == 0) dv8 = 1'b0;
            exp_bit = (k < W8) ? w8[W8-1-k] : ^w8;
            check("w8_x", x8, exp_bit);
            check("w8_last", xl8, k == FL8 - 1);
         end
      end
      @(negedge clk);
      check("w8_idle_x_valid", xv8, 0);
      check("w8_word_cnt", wc8, 2);

      // Random traffic on the narrow instance with occasional mid-frame resets.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         din = W3'($urandom);
         din_valid = ($urandom_range(0, 9) < 7);
         if (i % 97 == 50) begin
            @(posedge clk); #2 rst_n = 1'b0;
            @(posedge clk); #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      din_valid = 1'b0;
      repeat (FL3 + 2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
